// File: rtl/sample_window_capture_pkg.sv
// Shared audio package: sample width default, ADC zero level, capture FSM states
// and the saturating counter helper used by the capture block.
package sample_window_capture_pkg;

  localparam int unsigned SAMPLE_W_DEF = 10;
  localparam int unsigned MIDSCALE_DEF = 512;
  localparam logic [7:0]  OVR_MAX      = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FILL  = 2'd2,
    READY = 2'd3
  } cap_state_t;

  // Increment an 8-bit counter, holding at its maximum.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == OVR_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sample_window_capture_if.sv
// Control/data bundle between the capture block and its producer/consumer.
// master: the side feeding samples and consuming windows; slave: the capture block.
interface sample_window_capture_if
  import sample_window_capture_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned WIN_LEN  = 4
);

  logic                arm;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                consume;
  logic [SAMPLE_W-1:0] window [WIN_LEN];
  logic                win_ready;
  logic                busy;
  logic [7:0]          overrun_cnt;

  modport master (
    output arm, sample_valid, sample, consume,
    input  window, win_ready, busy, overrun_cnt
  );

  modport slave (
    input  arm, sample_valid, sample, consume,
    output window, win_ready, busy, overrun_cnt
  );

endinterface

// File: rtl/sample_window_capture_trigger_detect.sv
// Combinational |sample - MIDSCALE| >= THRESH detector. Also usable as a
// silence detector by inverting hit.
module trigger_detect
  import sample_window_capture_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned MIDSCALE = MIDSCALE_DEF,
  parameter int unsigned THRESH   = 64
) (
  input  logic [SAMPLE_W-1:0] sample,
  output logic                hit
);

  // One extra bit holds both the signed difference and its magnitude without overflow.
  localparam logic signed [SAMPLE_W:0] MID_S = (SAMPLE_W+1)'(MIDSCALE);
  localparam logic signed [SAMPLE_W:0] THR_S = (SAMPLE_W+1)'(THRESH);

  logic signed [SAMPLE_W:0] diff;
  logic signed [SAMPLE_W:0] mag;

  // Magnitude about the ADC zero level and threshold compare.
  always_comb begin
    diff = $signed({1'b0, sample}) - MID_S;
    mag  = diff[SAMPLE_W] ? -diff : diff;
    hit  = (mag >= THR_S);
  end

endmodule

// File: rtl/sample_window_capture.sv
// Triggered audio window capture: waits for an above-threshold sample, stores
// WIN_LEN consecutive valid samples in flops, and holds them until consumed.
module sample_window_capture
  import sample_window_capture_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned WIN_LEN  = 4,
  parameter int unsigned MIDSCALE = MIDSCALE_DEF,
  parameter int unsigned THRESH   = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sample_window_capture_if.slave bus
);

  localparam int unsigned      IDX_W    = $clog2(WIN_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  cap_state_t          state, state_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [7:0]          ovr, ovr_n;
  logic                wr_en;
  logic                hit;
  logic [SAMPLE_W-1:0] win_q [WIN_LEN];

  trigger_detect #(
    .SAMPLE_W (SAMPLE_W),
    .MIDSCALE (MIDSCALE),
    .THRESH   (THRESH)
  ) u_trig (
    .sample (bus.sample),
    .hit    (hit)
  );

  // State, write index and overrun counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      ovr   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      ovr   <= ovr_n;
    end
  end

  // Next-state, index advance, write enable and overrun counting.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    ovr_n   = ovr;
    wr_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.arm) begin
          state_n = ARMED;
          idx_n   = '0;
          ovr_n   = '0;
        end
      end
      ARMED: begin
        if (bus.sample_valid && hit) begin
          wr_en   = 1'b1;
          idx_n   = IDX_W'(1);
          state_n = FILL;
        end
      end
      FILL: begin
        if (bus.sample_valid) begin
          wr_en = 1'b1;
          if (idx == LAST_IDX) begin
            state_n = READY;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      READY: begin
        if (bus.sample_valid) begin
          ovr_n = sat_inc8(ovr);
        end
        if (bus.consume) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Window storage: parallel-readable flops written at the current index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < WIN_LEN; i++) begin
        win_q[i] <= '0;
      end
    end else if (wr_en) begin
      win_q[idx] <= bus.sample;
    end
  end

  assign bus.window      = win_q;
  assign bus.win_ready   = (state == READY);
  assign bus.busy        = (state == ARMED) || (state == FILL);
  assign bus.overrun_cnt = ovr;

endmodule

// File: tb/tb_sample_window_capture.sv
// Scoreboard bench for sample_window_capture: expected windows are queued as
// stimulus completes them; a negedge monitor checks each win_ready rise.
module tb_sample_window_capture;

  localparam int W = 10;
  localparam int L = 4;

  typedef struct {
    logic [W*L-1:0] win;
    int             cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  logic prev_rdy = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sample_window_capture_if #(.SAMPLE_W(W), .WIN_LEN(L)) bus ();

  sample_window_capture #(
    .SAMPLE_W (W),
    .WIN_LEN  (L),
    .MIDSCALE (512),
    .THRESH   (64)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [W*L-1:0] pack4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic logic [W*L-1:0] get_win();
    logic [W*L-1:0] r;
    for (int i = 0; i < L; i++) r[i*W +: W] = bus.window[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mon_step();
    exp_t e;
    if (bus.win_ready && !prev_rdy) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_window: got win_ready=1 expected no window at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        check("window", get_win(), e.win);
        check("ready_latency_cycle", cyc, e.cyc);
      end
    end
    prev_rdy = bus.win_ready;
  endtask

  always @(negedge clk) mon_step();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    bus.sample_valid = 1'b1;
    bus.sample       = W'(v);
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic pulse_consume();
    bus.consume = 1'b1;
    tick();
    bus.consume = 1'b0;
  endtask

  task automatic expect_win(input logic [W*L-1:0] w);
    exp_t e;
    e.win = w;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.arm = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample = '0;
    bus.consume = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    check("rst_win_ready", bus.win_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun_cnt, 0);
    check("rst_window", get_win(), 0);
    reset_n = 1'b1;
    tick();

    // Basic capture: 500/530 below threshold, 600 triggers.
    pulse_arm();
    check("armed_busy", bus.busy, 1);
    send(500);
    send(530);
    check("below_thresh_not_stored", get_win(), 0);
    send(600);
    send(100);
    send(700);
    check("not_ready_mid_fill", bus.win_ready, 0);
    send(512);
    expect_win(pack4(600, 100, 700, 512));
    check("ready_not_busy", bus.busy, 0);

    // Overrun in READY, then consume.
    send(1);
    send(2);
    send(3);
    check("overrun_3", bus.overrun_cnt, 3);
    check("ready_window_held", get_win(), pack4(600, 100, 700, 512));
    pulse_consume();
    check("consume_ready_low", bus.win_ready, 0);
    check("consume_busy_low", bus.busy, 0);
    check("consume_window_kept", get_win(), pack4(600, 100, 700, 512));
    check("overrun_kept_in_idle", bus.overrun_cnt, 3);
    pulse_consume();
    check("consume_idle_ignored", bus.busy, 0);

    // Threshold boundaries, stalls, and arm while busy.
    pulse_arm();
    check("arm_clears_overrun", bus.overrun_cnt, 0);
    send(575);
    check("mag63_no_trigger", get_win(), pack4(600, 100, 700, 512));
    send(576);
    repeat (3) tick();
    send(1);
    pulse_arm();
    send(2);
    repeat (2) tick();
    send(3);
    expect_win(pack4(576, 1, 2, 3));
    pulse_consume();
    pulse_arm();
    send(575);
    send(448);
    send(10);
    send(20);
    send(30);
    expect_win(pack4(448, 10, 20, 30));

    // arm and consume together in READY: consume wins.
    bus.arm = 1'b1;
    bus.consume = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.consume = 1'b0;
    check("arm_consume_busy", bus.busy, 0);
    check("arm_consume_ready", bus.win_ready, 0);
    send(1000);
    check("idle_ignores_samples", get_win(), pack4(448, 10, 20, 30));

    // Overrun saturation.
    pulse_arm();
    send(900);
    send(11);
    send(12);
    send(13);
    expect_win(pack4(900, 11, 12, 13));
    for (int i = 0; i < 300; i++) send(i);
    check("overrun_sat", bus.overrun_cnt, 255);
    for (int i = 0; i < 5; i++) send(i + 40);
    check("overrun_sat_held", bus.overrun_cnt, 255);
    check("sat_window_held", get_win(), pack4(900, 11, 12, 13));

    // Asynchronous reset while READY.
    #2 reset_n = 1'b0;
    #1;
    check("rst_ready_win_ready", bus.win_ready, 0);
    check("rst_ready_overrun", bus.overrun_cnt, 0);
    check("rst_ready_window", get_win(), 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Asynchronous reset mid-FILL, then a clean capture.
    pulse_arm();
    send(600);
    send(601);
    #2 reset_n = 1'b0;
    #1;
    check("rst_fill_busy", bus.busy, 0);
    check("rst_fill_win_ready", bus.win_ready, 0);
    check("rst_fill_window", get_win(), 0);
    tick();
    reset_n = 1'b1;
    tick();
    pulse_arm();
    send(500);
    send(700);
    send(5);
    send(6);
    send(7);
    expect_win(pack4(700, 5, 6, 7));

    repeat (3) tick();
    check("exp_queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_window_capture.md
SAMPLE_WINDOW_CAPTURE -- requirements
Module: sample_window_capture

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 10, width of one audio sample.
REQ-002 SHALL have parameter WIN_LEN, default 4, samples per window, 2 to 2048.
REQ-003 SHALL have parameter MIDSCALE, default 512, unsigned ADC zero level.
REQ-004 SHALL have parameter THRESH, default 64, trigger magnitude about MIDSCALE.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset, asynchronous assert, active-low.
REQ-007 SHALL have port arm, input, 1, a one-cycle pulse that starts a capture.
REQ-008 SHALL have port sample_valid, input, 1, sample is valid this cycle.
REQ-009 SHALL have port sample, input, SAMPLE_W, unsigned ADC code.
REQ-010 SHALL have port consume, input, 1, a one-cycle pulse meaning the downstream correlator has finished with the window.
REQ-011 SHALL have port window, output, WIN_LEN x SAMPLE_W unpacked array, the captured samples; index 0 is the oldest.
REQ-012 SHALL have port win_ready, output, 1, window is complete and stable.
REQ-013 SHALL have port busy, output, 1, the block is in the ARMED or FILL state.
REQ-014 SHALL have port overrun_cnt, output, 8, count of samples dropped while in READY; saturates at 255.

Function
REQ-015 SHALL implement a four-state FSM: IDLE, ARMED, FILL, READY.
REQ-016 SHALL go IDLE->ARMED on arm; SHALL ignore arm in every other state.
REQ-017 In ARMED, for a valid sample, SHALL compute mag = |sample - MIDSCALE| at SAMPLE_W+1 bits, signed, with no overflow.
REQ-018 In ARMED, a valid sample with mag >= THRESH SHALL be stored at index 0, and the state SHALL go to FILL; samples below threshold SHALL be discarded.
REQ-019 In FILL, each valid sample SHALL be stored at the next index; on the cycle the write index reaches WIN_LEN-1, the state SHALL go to READY.
REQ-020 win_ready SHALL assert on the first cycle after the final sample's clock edge, so the latency from the last sample_valid to win_ready is 1 cycle.
REQ-021 In READY, window SHALL hold constant, and sample_valid SHALL increment overrun_cnt (saturating) without writing.
REQ-022 In READY, consume SHALL return the state to IDLE and deassert win_ready the next cycle; window contents SHALL be retained until the next trigger.
REQ-023 consume outside READY SHALL be ignored.
REQ-024 If arm and consume coincide in READY, consume SHALL win, and arm SHALL be ignored.
REQ-025 sample_valid low SHALL stall ARMED and FILL with no state or index change; gaps of any length are legal.
REQ-026 overrun_cnt SHALL clear only on reset, or on arm accepted in IDLE.
REQ-027 The write index SHALL be $clog2(WIN_LEN) bits and SHALL reset to 0 on every entry to ARMED.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, with win_ready=0, busy=0, overrun_cnt=0, write index 0, and all window entries 0.
REQ-029 Reset mid-FILL or mid-READY SHALL discard the partial or complete window; no pulse SHALL be emitted.
REQ-030 Reset deassertion SHALL be synchronised by the integrator, not inside this block.

Structure
REQ-031 The SAMPLE_W default, the FSM state enum, and the MIDSCALE constant SHALL live in the shared audio package, used by the correlator and the bank compare.
REQ-032 SHALL contain one sub-module, trigger_detect: combinational magnitude-versus-threshold, reusable for silence detection.
REQ-033 Storage SHALL be flops, not inferred RAM, so the whole window is readable in parallel by the correlator.

Verification
REQ-034 Scenario: arm; feed 500,530,600,100,700,512 → 600 triggers; window = {600,100,700,512}; win_ready 1 cycle after 512.
REQ-035 Scenario: READY then 3 extra valid samples → window unchanged, overrun_cnt = 3; consume → IDLE, win_ready = 0 next cycle.
REQ-036 Scenario: reset_n low after 2 FILL samples → immediately IDLE, all outputs and the window zero; a fresh arm captures a clean window.
REQ-037 Scenario: sample = 576 (mag 64) triggers; 575 (mag 63) does not; sample = 448 (mag 64) triggers.
REQ-038 Scenario: arm and consume in the same READY cycle → IDLE, not ARMED; arm while busy → no effect.
REQ-039 Scenario: 300 dropped samples in READY → overrun_cnt = 255, held.
